axi4_lite_read_master: RTL
==========================

Name: axi4_lite_read_master

Overview:
AXI4-Lite read-channel initiator that turns single-word load requests from a core-side port into AR/R handshakes. It drives the master end of the read address and read data channels that our read slaves terminate. One transaction is outstanding at a time. Returned data and an error flag go back to the requester as a one-cycle response strobe.

Parameters:
ADDR_WIDTH, 32, width of request address and M_AXI_ARADDR
DATA_WIDTH, 32, width of response data and M_AXI_RDATA
TIMEOUT_CYCLES, 256, watchdog limit in cycles per channel phase; used only when AXI_RD_TIMEOUT_EN is defined

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  core requests a read
req_addr  in  ADDR_WIDTH  read address; sampled when req_valid && req_ready
req_ready  out  1  master idle and able to accept a request
resp_valid  out  1  one-cycle pulse: resp_data/resp_err valid
resp_data  out  DATA_WIDTH  captured read data; held until next capture
resp_err  out  1  1 when captured RRESP[1]==1 (SLVERR/DECERR) or on timeout
M_AXI_ARADDR  out  ADDR_WIDTH  read address
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  slave accepts address
M_AXI_RDATA  in  DATA_WIDTH  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  master accepts read data

Behaviour:
- Reset (async, immediate): state ST_IDLE; M_AXI_ARVALID=0, M_AXI_RREADY=0, M_AXI_ARADDR=0, resp_valid=0, resp_data=0, resp_err=0. In ST_IDLE req_ready=1.
- Reset mid-transaction: ARVALID/RREADY drop in the same cycle; the in-flight request is discarded and no resp_valid is issued.
- FSM states:
  - ST_IDLE: req_ready=1. On req_valid, latch req_addr into the ARADDR register and go to ST_ADDR.
  - ST_ADDR: ARVALID=1. ARADDR is held stable. ARVALID never depends on ARREADY and never deasserts before the handshake. When ARVALID&&ARREADY, go to ST_DATA.
  - ST_DATA: RREADY=1. When RVALID, capture RDATA into resp_data, set resp_err=RRESP[1], go to ST_RESP.
  - ST_RESP: resp_valid=1 for exactly one cycle, then ST_IDLE.
- All AXI outputs are registered or decoded directly from state; no combinational path from AXI inputs to AXI outputs.
- Best-case latency with ARREADY and RVALID each asserted on the first eligible cycle:
  - req accepted at edge 0
  - ARVALID high in cycle 1, handshake at edge 1
  - RREADY high in cycle 2, RVALID sampled at edge 2
  - resp_valid in cycle 3
  - next request accepted in cycle 4
- Throughput: at most one read per 4 cycles.
- RVALID outside ST_DATA is ignored (RREADY=0). req_valid outside ST_IDLE is ignored (req_ready=0); the requester holds the request.
- RRESP=EXOKAY is treated as OKAY (resp_err=0).
- Slave stalls: ARREADY low holds ST_ADDR indefinitely; RVALID low holds ST_DATA indefinitely (unless the optional feature is enabled).
- M_AXI_ARADDR is held after the handshake until the next request is latched.

Optional Feature:
- Macro AXI_RD_TIMEOUT_EN, when defined:
  - A counter clears on entry to ST_ADDR and on entry to ST_DATA, and increments each cycle in those states.
  - On reaching TIMEOUT_CYCLES-1 without the handshake, the FSM goes to ST_RESP with resp_err=1 and resp_data=0.
  - ARVALID/RREADY deassert; this is accepted as fault recovery for a hung slave.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Without the macro: no counter, the master waits indefinitely, and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - RRESP constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - the read-master state enum typedef (2-bit: ST_IDLE, ST_ADDR, ST_DATA, ST_RESP)
- No sub-module. The timeout counter stays inline.

Test Plan:
- Zero-wait slave: req_addr=0x0000_1000, slave returns RDATA=0xDEAD_BEEF, RRESP=00 -> ARADDR=0x1000 in cycle 1, resp_valid in cycle 3, resp_data=0xDEADBEEF, resp_err=0.
- ARREADY delayed 5 cycles -> ARVALID stays 1 and ARADDR stays stable for 6 cycles; RREADY=0 throughout; response arrives 5 cycles later than the zero-wait case.
- RRESP=2'b10 with RDATA=0x1234_5678 -> resp_err=1, resp_data=0x12345678; RRESP=2'b01 -> resp_err=0.
- Back-to-back: req_valid held high with addrs 0x10 then 0x14 -> second AR handshake occurs 4 cycles after the first; req_ready low while busy.
- Async rst asserted mid-cycle in ST_DATA -> ARVALID/RREADY/resp_valid drop before the next clock edge; no resp_valid after reset release.
- With AXI_RD_TIMEOUT_EN and TIMEOUT_CYCLES=16, ARREADY never asserted -> resp_valid with resp_err=1 and resp_data=0 after 16 cycles in ST_ADDR; returns to ST_IDLE.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes and read-master state encoding
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } rd_state_e;

    // EXOKAY is never requested by a Lite master, so it reads as a plain success.
    function automatic logic resp_is_error(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY, RESP_EXOKAY: err = 1'b0;
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/axi4_lite_read_master.sv
// rtl/axi4_lite_read_master.sv - single-outstanding AXI4-Lite read initiator; AXI_RD_TIMEOUT_EN adds a per-phase watchdog
module axi4_lite_read_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    rd_state_e             state;
    rd_state_e             state_next;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
    logic                  timeout;

`ifdef AXI_RD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    // Any state change restarts the count, which covers entry to both waiting phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state_next != state) begin
            to_cnt <= '0;
        end else if (state == ST_ADDR || state == ST_DATA) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = (state == ST_ADDR || state == ST_DATA) && (to_cnt == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (M_AXI_ARREADY) begin
                    state_next = ST_DATA;
                end else if (timeout) begin
                    state_next = ST_RESP;
                end
            end
            ST_DATA: begin
                if (M_AXI_RVALID || timeout) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            araddr_q <= '0;
        end else if (state == ST_IDLE && req_valid) begin
            araddr_q <= req_addr;
        end
    end

    // Response payload persists until the next capture so the requester may read it late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (state == ST_DATA && M_AXI_RVALID) begin
            data_q <= M_AXI_RDATA;
            err_q  <= resp_is_error(M_AXI_RRESP);
        end else if (timeout && state_next == ST_RESP) begin
            data_q <= '0;
            err_q  <= 1'b1;
        end
    end

    assign req_ready     = (state == ST_IDLE);
    assign M_AXI_ARVALID = (state == ST_ADDR);
    assign M_AXI_RREADY  = (state == ST_DATA);
    assign resp_valid    = (state == ST_RESP);
    assign M_AXI_ARADDR  = araddr_q;
    assign resp_data     = data_q;
    assign resp_err      = err_q;

endmodule
